store_db: RTL and testbench

- Consumer end of the deblocked-pixel store interface.
- After each LCU is deblocked and its buffer reports ready, store_db reads all 192 rows of 32 pixels from that buffer: 128 luma rows, then 64 interleaved-UV chroma rows.
- It writes each row to external frame memory through a req/ack write port, then pulses store-done so the buffer rotates.
- It sits between the deblocking pixel buffers and the external memory arbiter.

---
 rtl/store_db_pkg.sv | 44 ++++
 rtl/store_db_if.sv | 15 +
 rtl/store_db_fifo.sv | 52 +++++
 rtl/store_db.sv | 135 +++++++++++++
 tb/tb_store_db.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_db_pkg.sv
// Shared constants, FSM encoding and row-address helper for the deblocked-pixel store path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package store_db_pkg;

  // Bits per pixel, matching the encoder-wide pixel width.
  localparam int PIXEL_WIDTH = 8;
  localparam int ROW_PIX     = 32;
  localparam int ROW_W       = ROW_PIX * PIXEL_WIDTH;

  localparam int LUMA_ROWS   = 128;
  localparam int CHROMA_ROWS = 64;
  localparam int TOTAL_ROWS  = LUMA_ROWS + CHROMA_ROWS;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_READ     = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // Pixel offset of buffer row 'row' inside its plane (the plane base is added by the caller).
  // Luma rows pair up as left/right 32-pixel halves of one 64-pixel line; chroma rows do the
  // same over 32 interleaved-UV lines.
  function automatic logic [31:0] row_offset(input logic [7:0]  row,
                                             input logic [7:0]  lcu_x,
                                             input logic [7:0]  lcu_y,
                                             input logic [12:0] width);
    logic [31:0] line;
    logic [31:0] col;
    logic [7:0]  k;
    k = row - 8'(LUMA_ROWS);
    if (row < 8'(LUMA_ROWS)) begin
      line = {18'd0, lcu_y, 6'd0} + {26'd0, row[6:1]};
      col  = {18'd0, lcu_x, 6'd0} + {26'd0, row[0], 5'd0};
    end else begin
      line = {19'd0, lcu_y, 5'd0} + {27'd0, k[5:1]};
      col  = {18'd0, lcu_x, 6'd0} + {26'd0, k[0], 5'd0};
    end
    return line * {19'd0, width} + col;
  endfunction

endpackage

// File: rtl/store_db_if.sv
// External frame-memory write port: one 32-pixel row per req/ack handshake.
// Latency: n/a (wiring only).
// Backpressure: master holds req/addr/data stable until the slave raises ack.
interface store_db_if #(
  parameter int AW = 32,
  parameter int DW = store_db_pkg::ROW_W
);
  logic          ext_wr_req;
  logic [AW-1:0] ext_wr_addr;
  logic [DW-1:0] ext_wr_data;
  logic          ext_wr_ack;

  modport master (output ext_wr_req, ext_wr_addr, ext_wr_data, input ext_wr_ack);
  modport slave  (input ext_wr_req, ext_wr_addr, ext_wr_data, output ext_wr_ack);
endinterface

// File: rtl/store_db_fifo.sv
// Two-entry FIFO holding {external address, row pixels} between buffer read and memory write.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is dropped when full unless a pop frees the slot in the same cycle.
module store_db_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == 2'd0);

  // Storage, pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/store_db.sv
// Reads the 192 rows of a deblocked LCU from its pixel buffer and writes them to frame memory.
// Latency: buffer data lands in the FIFO one cycle after the read; 1 row/cycle with ack held high.
// Backpressure: ext_wr_ack stalls the FIFO head; reads pause so FIFO plus in-flight never exceeds 2.
module store_db
  import store_db_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] LUMA_BASE   = '0,
  parameter logic [ADDR_WIDTH-1:0] CHROMA_BASE = ADDR_WIDTH'(32'h0010_0000)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic [7:0]       lcu_x_i,
  input  logic [7:0]       lcu_y_i,
  input  logic [12:0]      frame_width_i,
  input  logic             ext_store_ready_i,
  output logic             ext_store_en_o,
  output logic [7:0]       ext_store_addr_o,
  input  logic [ROW_W-1:0] ext_store_data_i,
  output logic             ext_store_done_o,
  store_db_if.master       wr,
  output logic             busy_o
);

  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic [7:0]            rd_cnt_q;
  logic [7:0]            lcu_x_q;
  logic [7:0]            lcu_y_q;
  logic [12:0]           width_q;
  logic                  rvld_q;
  logic [ADDR_WIDTH-1:0] pipe_addr_q;

  logic [1:0]                  fifo_cnt;
  logic                        fifo_empty;
  logic [ADDR_WIDTH+ROW_W-1:0] fifo_head;
  logic                        pop;
  logic [2:0]                  occ;
  logic                        rd_en;
  logic [ADDR_WIDTH-1:0]       row_addr;

  // Occupancy after this cycle's pop plus the row still in flight from last cycle's read.
  // Counting the pop is what lets a full-rate stream run with ack held high.
  assign pop   = !fifo_empty && wr.ext_wr_ack;
  assign occ   = {1'b0, fifo_cnt} - {2'b0, pop} + {2'b0, rvld_q};
  assign rd_en = (state_q == ST_READ) && (occ < 3'd2);

  assign row_addr = ((rd_cnt_q < 8'(LUMA_ROWS)) ? LUMA_BASE : CHROMA_BASE)
                  + ADDR_WIDTH'(row_offset(rd_cnt_q, lcu_x_q, lcu_y_q, width_q));

  assign ext_store_en_o   = rd_en;
  assign ext_store_addr_o = rd_cnt_q;
  assign ext_store_done_o = done_q;
  assign busy_o           = busy_q;

  assign wr.ext_wr_req                    = !fifo_empty;
  assign {wr.ext_wr_addr, wr.ext_wr_data} = fifo_head;

  // Job sequencing: latch job, wait for a full buffer, stream rows, drain, pulse done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_cnt_q <= 8'd0;
      lcu_x_q  <= 8'd0;
      lcu_y_q  <= 8'd0;
      width_q  <= 13'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            lcu_x_q  <= lcu_x_i;
            lcu_y_q  <= lcu_y_i;
            width_q  <= frame_width_i;
            rd_cnt_q <= 8'd0;
            busy_q   <= 1'b1;
            state_q  <= ST_WAIT_RDY;
          end
        end
        // Ready is only a job-level go signal; once reading starts it is not looked at.
        ST_WAIT_RDY: if (ext_store_ready_i) state_q <= ST_READ;
        ST_READ: begin
          if (rd_en) begin
            if (rd_cnt_q == 8'(TOTAL_ROWS - 1)) begin
              rd_cnt_q <= 8'd0;
              state_q  <= ST_DRAIN;
            end else begin
              rd_cnt_q <= rd_cnt_q + 8'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (fifo_empty && !rvld_q) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Address is formed at issue time and delayed one cycle so it meets its row data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvld_q      <= 1'b0;
      pipe_addr_q <= '0;
    end else begin
      rvld_q <= rd_en;
      if (rd_en) pipe_addr_q <= row_addr;
    end
  end

  store_db_fifo #(
    .W (ADDR_WIDTH + ROW_W)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (rvld_q),
    .pop_i   (pop),
    .din_i   ({pipe_addr_q, ext_store_data_i}),
    .dout_o  (fifo_head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_store_db.sv
// Randomized bench for store_db against a plane-address / row-pattern reference model.
// Latency: buffer model returns row data one cycle after each read enable.
// Backpressure: write ack driven randomly at a per-test percentage.
module tb_store_db;
  import store_db_pkg::*;

  localparam int DW = ROW_W;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic [7:0]    lx = '0;
  logic [7:0]    ly = '0;
  logic [12:0]   fw = '0;
  logic          en;
  logic [7:0]    raddr;
  logic [DW-1:0] rdata;
  logic          done;
  logic          busy;

  store_db_if wr_bus ();

  store_db dut (
    .clk               (clk),
    .rstn              (rstn),
    .start_i           (start),
    .lcu_x_i           (lx),
    .lcu_y_i           (ly),
    .frame_width_i     (fw),
    .ext_store_ready_i (ready),
    .ext_store_en_o    (en),
    .ext_store_addr_o  (raddr),
    .ext_store_data_i  (rdata),
    .ext_store_done_o  (done),
    .wr                (wr_bus),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [255:0] act_v, input logic [255:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act_v, exp_v);
    end
  endtask

  // Reference: plane address of row r for the LCU at (x,y) in a frame w pixels wide.
  function automatic logic [31:0] exp_addr(input int r, input int x, input int y, input int w);
    longint a;
    if (r < 128) a = longint'(y * 64 + r / 2) * w + x * 64 + (r % 2) * 32;
    else         a = 64'h10_0000 + longint'(y * 32 + (r - 128) / 2) * w + x * 64 + ((r - 128) % 2) * 32;
    return a[31:0];
  endfunction

  // Row-indexed pixel pattern served by the buffer model.
  function automatic logic [DW-1:0] pat(input int r, input int seed);
    logic [DW-1:0] v;
    for (int i = 0; i < 32; i++) v[i*8 +: 8] = 8'(r * 3 + i * 17 + seed);
    return v;
  endfunction

  // Job parameters seen by the model (only changed for starts that should be accepted).
  int j_x = 0, j_y = 0, j_w = 0, j_seed = 0;
  int ack_pct = 100;

  // Monitor state.
  int wr_idx = 0, rd_exp = 0, rd_tot = 0, done_cnt = 0, cnt_m = 0;
  int cyc = 0, first_cyc = 0, last_cyc = 0, done_cyc = 0;
  logic prev_en = 1'b0, prev_done = 1'b0, hold_vld = 1'b0, pop_m;
  logic [7:0]    prev_addr = '0;
  logic [31:0]   hold_addr = '0;
  logic [DW-1:0] hold_data = '0;
  logic [31:0]   got_addr [192];

  // Buffer/memory model: drives data and ack just after each edge, checks at the falling edge.
  initial begin
    wr_bus.ext_wr_ack = 1'b0;
    rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_en) rdata = pat(int'(prev_addr), j_seed);
      else for (int k = 0; k < DW / 32; k++) rdata[k*32 +: 32] = $urandom;
      wr_bus.ext_wr_ack = ($urandom_range(0, 99) < ack_pct);
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        wr_idx = 0; rd_exp = 0; cnt_m = 0;
        prev_en = 1'b0; prev_done = 1'b0; hold_vld = 1'b0;
      end else begin
        pop_m = wr_bus.ext_wr_req && wr_bus.ext_wr_ack;
        if (hold_vld) begin
          chk("wr_hold_req", wr_bus.ext_wr_req, 1'b1);
          chk("wr_hold_addr", wr_bus.ext_wr_addr, hold_addr);
          chk("wr_hold_data", wr_bus.ext_wr_data, hold_data);
        end
        if (cnt_m != 0 || wr_bus.ext_wr_req) chk("wr_req_lvl", wr_bus.ext_wr_req, cnt_m != 0);
        if (pop_m) begin
          chk("wr_addr", wr_bus.ext_wr_addr, exp_addr(wr_idx, j_x, j_y, j_w));
          chk("wr_data", wr_bus.ext_wr_data, pat(wr_idx, j_seed));
          if (wr_idx == 0) first_cyc = cyc;
          last_cyc = cyc;
          if (wr_idx < 192) got_addr[wr_idx] = wr_bus.ext_wr_addr;
          wr_idx++;
        end
        if (en) begin
          chk("rd_addr", raddr, rd_exp);
          rd_exp++;
          rd_tot++;
        end
        if (prev_en) chk("fifo_ovf", (cnt_m + 1 - int'(pop_m)) <= 2, 1'b1);
        cnt_m = cnt_m + int'(prev_en) - int'(pop_m);
        if (done) begin
          chk("done_rows", wr_idx, 192);
          chk("done_no_rd", en, 1'b0);
          chk("done_1cyc", prev_done, 1'b0);
          done_cnt++;
          done_cyc = cyc;
          wr_idx = 0;
          rd_exp = 0;
        end
        prev_done = done;
        hold_vld  = wr_bus.ext_wr_req && !wr_bus.ext_wr_ack;
        hold_addr = wr_bus.ext_wr_addr;
        hold_data = wr_bus.ext_wr_data;
        prev_en   = en;
        prev_addr = raddr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_job(input int x, input int y, input int w);
    int k = 0;
    while (busy && k < 100) begin tick(); k++; end
    j_x = x; j_y = y; j_w = w; j_seed = $urandom_range(0, 255);
    lx = 8'(x); ly = 8'(y); fw = 13'(w);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_job(input string tag);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < 3000) begin tick(); k++; end
    repeat (5) tick();
    chk({tag, "_done_cnt"}, done_cnt - d0, 1);
    chk({tag, "_busy_low"}, busy, 1'b0);
  endtask

  task automatic wait_rows(input int n, input string tag);
    int k = 0;
    while (wr_idx < n && k < 3000) begin tick(); k++; end
    chk({tag, "_rows_reached"}, wr_idx >= n, 1'b1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_en"}, en, 1'b0);
    chk({tag, "_raddr"}, raddr, 8'd0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_req"}, wr_bus.ext_wr_req, 1'b0);
    chk({tag, "_waddr"}, wr_bus.ext_wr_addr, 32'd0);
    chk({tag, "_wdata"}, wr_bus.ext_wr_data, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, d1, r0, dd;
    repeat (3) tick();
    check_reset("rst");
    rstn = 1'b1;
    tick();

    // Full rate, no backpressure.
    ack_pct = 100; ready = 1'b1;
    start_job(1, 0, 128);
    finish_job("a");
    chk("a_row0", got_addr[0], 32'd64);
    chk("a_row1", got_addr[1], 32'd96);
    chk("a_row2", got_addr[2], 32'd192);
    chk("a_row128", got_addr[128], 32'h0010_0040);
    chk("a_rate", last_cyc - first_cyc, 191);

    // Same job under random backpressure.
    ack_pct = 30;
    start_job(1, 0, 128);
    finish_job("b");
    chk("b_row128", got_addr[128], 32'h0010_0040);

    // Buffer not ready for 20 cycles, then ready drops mid-read.
    ack_pct = 70; ready = 1'b0;
    start_job(2, 1, 256);
    r0 = rd_tot;
    repeat (20) tick();
    chk("c_no_rd", rd_tot - r0, 0);
    ready = 1'b1;
    @(negedge clk);
    chk("c_rd_lat0", en, 1'b0);
    @(negedge clk);
    chk("c_rd_lat1", en, 1'b1);
    repeat (5) tick();
    ready = 1'b0;
    finish_job("c");
    ready = 1'b1;

    // start pulsed while busy must be ignored.
    ack_pct = 60;
    start_job(3, 2, 192);
    wait_rows(50, "d");
    lx = 8'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_job("d");
    r0 = rd_tot;
    repeat (30) tick();
    chk("d_no_rerun", rd_tot - r0, 0);
    chk("d_busy", busy, 1'b0);

    // Back-to-back jobs.
    ack_pct = 100;
    start_job(0, 0, 128);
    finish_job("e1");
    a0 = int'(got_addr[0]);
    d1 = done_cyc;
    start_job(1, 0, 128);
    finish_job("e2");
    chk("e_offset", got_addr[0], 32'(a0 + 64));
    chk("e_done_gap", (done_cyc - d1) > 192, 1'b1);

    // Reset in the middle of a job.
    ack_pct = 50;
    start_job(1, 1, 128);
    wait_rows(100, "f");
    dd = done_cnt;
    #1;
    rstn = 1'b0;
    #1;
    check_reset("f_rst");
    repeat (3) tick();
    rstn = 1'b1;
    repeat (3) tick();
    chk("f_no_done", done_cnt - dd, 0);
    chk("f_idle", busy, 1'b0);
    start_job(1, 1, 128);
    finish_job("f2");
    chk("f2_row0", got_addr[0], 32'd8256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
